serial_collector: RTL
=====================

Name: serial_collector

Overview:
Receive-side counterpart of the serial adder control FSM. Captures the LSB-first serial sum stream and final carry produced under load/enable strobes, then reassembles them into a parallel word. Presents the word plus carry-out on a valid/ready handshake to downstream logic. Sits between the serial adder datapath and the parallel result consumer.

Parameters:
WIDTH, 8, number of sum bits per operation; legal range is WIDTH >= 2.

Ports:
clk_i  input  1  single clock, rising edge.
reset_i  input  1  asynchronous, active-high reset.
load_i  input  1  start of new operation; clears collector.
enable_i  input  1  sum_bit_i/carry_i valid this cycle.
sum_bit_i  input  1  serial sum bit, LSB first.
carry_i  input  1  adder carry accompanying current bit.
ready_i  input  1  downstream accepts sum_o/cout_o.
sum_o  output  WIDTH  assembled parallel sum.
cout_o  output  1  carry after final (MSB) bit.
valid_o  output  1  sum_o/cout_o hold an unconsumed word.
busy_o  output  1  collection in progress.
overrun_o  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, active-high): state C_IDLE; shift register and bit counter are 0; sum_o=0, cout_o=0, valid_o=0, busy_o=0, overrun_o=0. Reset mid-word discards the partial word and any held word.
- FSM states:
  - C_IDLE: enable_i is ignored. load_i moves to C_COLLECT, with count=0 and shreg=0.
  - C_COLLECT (busy_o=1): on each enable_i, shreg <= {sum_bit_i, shreg[WIDTH-1:1]} and count++. Cycles with enable_i low hold all state (gaps allowed).
- Completion: the enable_i cycle with count==WIDTH-1 is the final bit.
  - Next edge: output register takes {sum_bit_i, shreg[WIDTH-1:1]} and cout_o <= carry_i.
  - valid_o=1 from the cycle after the WIDTH-th enabled bit (latency 1).
  - State returns to C_IDLE and count resets to 0.
- Handshake:
  - valid_o, sum_o and cout_o remain stable until a clock with valid_o && ready_i, which clears valid_o.
  - ready_i while valid_o=0 has no effect.
- Simultaneous completion and acceptance (valid_o && ready_i on the completion edge): the new word is loaded and valid_o stays 1; no overrun.
- Completion while valid_o=1 && !ready_i: the new word is dropped, the held word is kept, and overrun_o is set. overrun_o clears only on reset.
- load_i in C_COLLECT: abort. Restart at count=0, shreg=0; the partial word is discarded. Held output is unaffected.
- load_i and enable_i in the same cycle: load wins; that bit is discarded.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1 (wrap to 0 at completion).

Optional Feature:
SERIAL_COLLECTOR_PARITY_EN
- Defined: adds output parity_o (1 bit) = XOR reduction of the assembled sum. It is registered on the same edge as sum_o, follows the same hold/drop rules, and resets to 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_pkg holds:
  - WIDTH default constant, shared with the adder control FSM.
  - typedef enum logic [0:0] collect_state_t {C_IDLE, C_COLLECT}.
- Natural sub-module serial_shift_in: shift register plus bit counter with load/enable inputs and a done pulse output.
- The top level keeps the FSM, output register, handshake and overrun logic.

Test Plan:
- Basic word, WIDTH=8, ready_i=1: load_i, then bits 1,1,1,1,1,1,1,0 with carry_i=0 -> sum_o=0x7F, cout_o=0, valid_o high exactly 1 cycle after the 8th bit.
- Carry out: bits of 0x00 with carry_i=1 on the final bit (0xFF+0x01) -> sum_o=0x00, cout_o=1.
- Gapped enable: word 0xA5 with enable_i low for 2 cycles between each bit -> sum_o=0xA5; busy_o=1 throughout; no early valid_o.
- Backpressure: ready_i=0, collect 0x3C then 0xC3 -> sum_o stays 0x3C and overrun_o=1. Raising ready_i clears valid_o; overrun_o stays 1.
- Abort and load priority: load_i, 3 bits, then load_i coincident with enable_i, then 8 bits of 0x5A -> sum_o=0x5A.
- Reset mid-word: reset_i after 4 bits with a word held -> all outputs 0 immediately. A following full 0x81 collects correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial adder datapath and its receive-side collector.
package serial_pkg;

    localparam int unsigned SERIAL_WIDTH = 8;

    typedef enum logic [0:0] {
        C_IDLE,
        C_COLLECT
    } collect_state_t;

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first shift register and bit counter; done_o flags the bit that completes a word.
module serial_shift_in
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o,
    output logic             done_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    // Only the upper WIDTH-1 bits are kept; the incoming bit completes the word.
    logic [WIDTH-2:0] shreg_q;
    logic [CW-1:0]    count_q;

    assign word_o = {bit_i, shreg_q};
    assign done_o = shift_i && (count_q == LastCount);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            shreg_q <= '0;
            count_q <= '0;
        end else if (shift_i) begin
            shreg_q <= word_o[WIDTH-1:1];
            count_q <= done_o ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_collector.sv
// Reassembles a serial sum stream into a parallel word on a valid/ready handshake.
// Define SERIAL_COLLECTOR_PARITY_EN to add a registered parity_o of the held word.
module serial_collector
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic             sum_bit_i,
    input  logic             carry_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             valid_o,
    output logic             busy_o,
`ifdef SERIAL_COLLECTOR_PARITY_EN
    output logic             parity_o,
`endif
    output logic             overrun_o
);

    collect_state_t   state_q;
    logic             shift;
    logic             done;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;
    logic             overrun_q;
`ifdef SERIAL_COLLECTOR_PARITY_EN
    logic             parity_q;
`endif

    // A load in the same cycle as enable wins, so that bit never reaches the shifter.
    assign shift = (state_q == C_COLLECT) && enable_i && !load_i;

    serial_shift_in #(
        .WIDTH(WIDTH)
    ) u_shift_in (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(load_i),
        .shift_i(shift),
        .bit_i  (sum_bit_i),
        .word_o (word_next),
        .done_o (done)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= C_IDLE;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SERIAL_COLLECTOR_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (load_i) state_q <= C_COLLECT;
                end
                C_COLLECT: begin
                    if (done) state_q <= C_IDLE;
                end
                default: state_q <= C_IDLE;
            endcase

            // A held word being accepted on the completion edge frees the slot.
            if (done) begin
                if (!valid_q || ready_i) begin
                    sum_q    <= word_next;
                    cout_q   <= carry_i;
                    valid_q  <= 1'b1;
`ifdef SERIAL_COLLECTOR_PARITY_EN
                    parity_q <= ^word_next;
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign valid_o   = valid_q;
    assign busy_o    = (state_q == C_COLLECT);
    assign overrun_o = overrun_q;
`ifdef SERIAL_COLLECTOR_PARITY_EN
    assign parity_o  = parity_q;
`endif

endmodule
